// File: rtl/ddr_frame_arbiter.sv
// DDR burst arbiter for a double-buffered camera-to-VGA frame store.
// Grants write bursts (camera FIFO drain) and read bursts (VGA FIFO fill)
// round-robin, tracks per-direction frame offsets and swaps banks on framesync.
module ddr_frame_arbiter #(
   parameter int unsigned BURST_LEN   = 32,
   parameter int unsigned FRAME_WORDS = 153600,
   parameter logic [23:0] BANK1_BASE  = 24'h040000,
   parameter int unsigned RD_THRESH   = 448
) (
   input  logic        ddr_clk,
   input  logic        ddr_rst_n,
   input  logic        ddr_init_done,
   input  logic        cam_framesync,
   input  logic        vga_framesync,
   input  logic [9:0]  wr_fifo_count,
   input  logic [9:0]  rd_fifo_count,
   input  logic        cmd_ready,
   input  logic        burst_done,
   output logic        cmd_en,
   output logic        cmd_rd,
   output logic [23:0] cmd_addr,
   output logic        wr_bank,
   output logic        rd_bank,
   output logic        frame_wr_done
);

   localparam int unsigned OFF_W  = 18;
   localparam int unsigned ADDR_W = 24;
   localparam int unsigned CNT_W  = 10;

   localparam logic [OFF_W-1:0] FRAME_OFF     = OFF_W'(FRAME_WORDS);
   localparam logic [OFF_W-1:0] BURST_OFF     = OFF_W'(BURST_LEN);
   localparam logic [CNT_W-1:0] BURST_CNT     = CNT_W'(BURST_LEN);
   localparam logic [CNT_W-1:0] RD_THRESH_CNT = CNT_W'(RD_THRESH);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_CMD  = 3'd1,
      WR_WAIT = 3'd2,
      RD_CMD  = 3'd3,
      RD_WAIT = 3'd4
   } state_t;

   state_t            state, state_n;
   logic [OFF_W-1:0]  wr_off, wr_off_n;
   logic [OFF_W-1:0]  rd_off, rd_off_n;
   logic              wr_bank_n, rd_bank_n;
   logic              last_full_bank, last_full_bank_n;
   logic              last_grant_rd, last_grant_rd_n;
   logic              cam_q, vga_q;
   logic              cam_pend, cam_pend_n;
   logic              vga_pend, vga_pend_n;
   logic              started;
   logic              cmd_en_n, cmd_rd_n, frame_wr_done_n;
   logic [ADDR_W-1:0] cmd_addr_n;

   logic              cam_rise, vga_rise;
   logic              wr_req, rd_req;

   // Burst start address within a bank.
   function automatic logic [ADDR_W-1:0] burst_addr(input logic bank,
                                                    input logic [OFF_W-1:0] off);
      return (bank ? BANK1_BASE : ADDR_W'(0)) + ADDR_W'(off);
   endfunction

   // Framesync edge detection and request qualification.
   always_comb begin
      cam_rise = cam_framesync & ~cam_q;
      vga_rise = vga_framesync & ~vga_q;
      wr_req   = (wr_fifo_count >= BURST_CNT) && (wr_off < FRAME_OFF);
      rd_req   = (rd_fifo_count < RD_THRESH_CNT) && (rd_off < FRAME_OFF);
   end

   // State, bookkeeping and registered outputs.
   always_ff @(posedge ddr_clk or negedge ddr_rst_n) begin
      if (!ddr_rst_n) begin
         state          <= IDLE;
         wr_off         <= '0;
         rd_off         <= '0;
         wr_bank        <= 1'b0;
         rd_bank        <= 1'b1;
         last_full_bank <= 1'b1;
         last_grant_rd  <= 1'b0;
         cam_q          <= 1'b0;
         vga_q          <= 1'b0;
         cam_pend       <= 1'b0;
         vga_pend       <= 1'b0;
         started        <= 1'b0;
         cmd_en         <= 1'b0;
         cmd_rd         <= 1'b0;
         cmd_addr       <= '0;
         frame_wr_done  <= 1'b0;
      end else begin
         state          <= state_n;
         wr_off         <= wr_off_n;
         rd_off         <= rd_off_n;
         wr_bank        <= wr_bank_n;
         rd_bank        <= rd_bank_n;
         last_full_bank <= last_full_bank_n;
         last_grant_rd  <= last_grant_rd_n;
         cam_q          <= cam_framesync;
         vga_q          <= vga_framesync;
         cam_pend       <= cam_pend_n;
         vga_pend       <= vga_pend_n;
         started        <= 1'b1;
         cmd_en         <= cmd_en_n;
         cmd_rd         <= cmd_rd_n;
         cmd_addr       <= cmd_addr_n;
         frame_wr_done  <= frame_wr_done_n;
      end
   end

   // Next-state: arbitration, handshakes, offset advance and bank swaps.
   always_comb begin
      state_n          = state;
      wr_off_n         = wr_off;
      rd_off_n         = rd_off;
      wr_bank_n        = wr_bank;
      rd_bank_n        = rd_bank;
      last_full_bank_n = last_full_bank;
      last_grant_rd_n  = last_grant_rd;
      cam_pend_n       = cam_pend | cam_rise;
      vga_pend_n       = vga_pend | vga_rise;
      cmd_rd_n         = cmd_rd;
      cmd_addr_n       = cmd_addr;
      frame_wr_done_n  = 1'b0;
      cmd_en_n         = 1'b0;

      unique case (state)
         IDLE: begin
            // Frame restarts take priority; VGA first so the new write bank
            // is always the opposite of the bank now being displayed.
            if (cam_pend_n || vga_pend_n) begin
               if (vga_pend_n) begin
                  rd_off_n  = '0;
                  rd_bank_n = last_full_bank;
               end
               if (cam_pend_n) begin
                  wr_off_n  = '0;
                  wr_bank_n = ~rd_bank_n;
               end
               cam_pend_n = 1'b0;
               vga_pend_n = 1'b0;
            end else if (started && ddr_init_done && (wr_req || rd_req)) begin
               if (rd_req && (!wr_req || !last_grant_rd)) begin
                  state_n         = RD_CMD;
                  last_grant_rd_n = 1'b1;
                  cmd_rd_n        = 1'b1;
                  cmd_addr_n      = burst_addr(rd_bank, rd_off);
               end else begin
                  state_n         = WR_CMD;
                  last_grant_rd_n = 1'b0;
                  cmd_rd_n        = 1'b0;
                  cmd_addr_n      = burst_addr(wr_bank, wr_off);
               end
            end
         end
         WR_CMD: begin
            if (cmd_ready) state_n = WR_WAIT;
         end
         WR_WAIT: begin
            if (burst_done) begin
               state_n  = IDLE;
               wr_off_n = wr_off + BURST_OFF;
               if (wr_off_n == FRAME_OFF) begin
                  frame_wr_done_n  = 1'b1;
                  last_full_bank_n = wr_bank;
               end
            end
         end
         RD_CMD: begin
            if (cmd_ready) state_n = RD_WAIT;
         end
         RD_WAIT: begin
            if (burst_done) begin
               state_n  = IDLE;
               rd_off_n = rd_off + BURST_OFF;
            end
         end
         default: state_n = IDLE;
      endcase

      cmd_en_n = (state_n == WR_CMD) || (state_n == RD_CMD);
   end

endmodule
